simple_bus_arbiter: RTL and testbench
=====================================

# simple_bus_arbiter

Round-robin arbiter and transaction sequencer that shares one `simple_bus` instance between `N_REQ` requesting masters. It collects per-requester requests, drives `gnt`, issues a one-cycle `start` with the winner's `mode`/`addr`/`data`, waits for `rdy`, and returns read data and a completion pulse. It sits between CPU-side masters and the bus slave, such as the memory module.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 8: bus address width, matching the `simple_bus` parameter.
- `DATA_WIDTH`, default 16: bus data width, matching the `simple_bus` parameter.
- `TIMEOUT`, default 15: maximum WAIT cycles before abort; used only with the macro.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request level.
- `req_mode`  in  2*N_REQ  packed mode; slice i belongs to requester i.
- `req_addr`  in  ADDR_WIDTH*N_REQ  packed address.
- `req_wdata`  in  DATA_WIDTH*N_REQ  packed write data.
- `gnt`  out  N_REQ  one-hot grant, or all zero.
- `done`  out  N_REQ  one-cycle completion pulse to the owner.
- `rdata`  out  DATA_WIDTH  captured bus data, valid while `done` is high.
- `err`  out  1  timeout flag, valid while `done` is high.
- `bus_start`  out  1  transaction start strobe.
- `bus_mode`  out  2  latched mode.
- `bus_addr`  out  ADDR_WIDTH  latched address.
- `bus_wdata`  out  DATA_WIDTH  latched write data.
- `bus_rdy`  in  1  slave completion.
- `bus_rdata`  in  DATA_WIDTH  slave read data, sampled when `bus_rdy` is 1.

## Operation
- FSM states are IDLE, GRANT, START, WAIT and DONE.
- **IDLE:** if any `req` bit is 1, the winner is the first set bit searching upward and wrapping from `last+1`. The winner index is registered, `gnt[winner]` is set, and the FSM moves to GRANT. If no `req` bit is set, the FSM stays in IDLE.
- **GRANT:** latches the winner's `req_mode`, `req_addr` and `req_wdata` slices into the `bus_*` registers, then moves to START.
- **START:** drives `bus_start=1` for exactly one cycle, then moves to WAIT. `bus_rdy` is ignored in START.
- **WAIT:** holds `bus_*` stable. When `bus_rdy=1`, it captures `bus_rdata` into `rdata`, sets `err=0`, and moves to DONE.
- **DONE:** `done[winner]=1` for one cycle. The block then sets `last<=winner` and clears `gnt`, and the FSM moves to IDLE.
- `gnt[winner]` stays high from GRANT through DONE inclusive. All other `gnt` bits stay 0.
- If `req[winner]` drops after the grant, the transaction still runs to DONE; the block never aborts a started bus cycle.
- New requests arriving during a transaction are only evaluated in IDLE.
- `rdata` and `err` hold their values until the next DONE.
- Reset sets `last` to `N_REQ-1`, so requester 0 wins first after reset.

## Timing
- Reset values:
  - FSM state is IDLE.
  - `gnt`, `done`, `bus_start`, `err`, `bus_mode`, `bus_addr`, `bus_wdata` and `rdata` are all 0.
- Reset asserted in any state, including mid-WAIT, returns all of the above to their reset values on the next edge. No `done` pulse is issued for the aborted transaction.
- Latency, with `req` first sampled at edge 0:
  - `gnt` is high after edge 0.
  - `bus_start` is high after edge 2.
  - The earliest `bus_rdy` is sampled at edge 3.
  - `done` is high after edge 3.
- Minimum of 5 cycles per transaction, including the return to IDLE.
- The next grant comes at the earliest one cycle after `done`.

## Configuration
- Macro `SIMPLE_BUS_ARB_TIMEOUT_EN`.
- **When defined:** a counter clears on entry to WAIT and increments once per WAIT cycle. If the counter reaches `TIMEOUT` without `bus_rdy`, the FSM moves to DONE with `err=1` and `rdata=0`. If `bus_rdy` arrives in the same cycle the count hits `TIMEOUT`, `rdy` wins and `err=0`.
- **When undefined:** there is no counter, WAIT lasts indefinitely, and `err` is constant 0.

## Test plan
- **Single request:** `req=4'b0010`, addr 0x3C, mode 2'b01, `bus_rdy` on the first WAIT cycle with `bus_rdata=0x1234`. Required response: `gnt=0010`, a one-cycle `bus_start` with `bus_addr=0x3C`, then `done=0010` with `rdata=0x1234` and `err=0`; 5 cycles total.
- **Simultaneous requests:** `req=4'b1111` held continuously after reset. Grant order must be 0,1,2,3,0, and `gnt` is never multi-hot.
- **Fairness:** `req=4'b0101` held, `bus_rdy` after 2 WAIT cycles. Grants must alternate 0,2,0,2.
- **Requester drops early:** `req[1]` drops in WAIT. The transaction still completes with `done[1]` pulsed, and there is no new grant to 1.
- **Timeout, macro defined:** `TIMEOUT=15` and `bus_rdy` never asserted. After 15 WAIT cycles, `done` pulses with `err=1` and `rdata=0`, and the next requester is granted. Separately, with `rdy` on the 15th cycle, `err` must be 0.
- **Reset mid-WAIT:** assert `reset` for 1 cycle during WAIT. All outputs are 0, there is no `done`, and requester 0 is granted first afterwards.

Source files
------------

// File: rtl/simple_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// simple_bus_arbiter_if
//
// Bundles the request side (N_REQ masters) and the simple_bus side of the
// round-robin arbiter into one interface.
//
//   Request side : req, req_mode, req_addr, req_wdata   (to arbiter)
//                  gnt, done, rdata, err                (from arbiter)
//   Bus side     : bus_start, bus_mode, bus_addr,
//                  bus_wdata                            (from arbiter)
//                  bus_rdy, bus_rdata                   (to arbiter)
//
// Modports:
//   master - the arbiter itself; it masters the shared simple_bus.
//   slave  - the environment: the requesting masters plus the bus slave.
//
// Packed request vectors hold one slice per requester; slice i belongs to
// requester i.
// -----------------------------------------------------------------------------
interface simple_bus_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);

  logic [N_REQ-1:0]            req;
  logic [2*N_REQ-1:0]          req_mode;
  logic [ADDR_WIDTH*N_REQ-1:0] req_addr;
  logic [DATA_WIDTH*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            done;
  logic [DATA_WIDTH-1:0]       rdata;
  logic                        err;

  logic                        bus_start;
  logic [1:0]                  bus_mode;
  logic [ADDR_WIDTH-1:0]       bus_addr;
  logic [DATA_WIDTH-1:0]       bus_wdata;
  logic                        bus_rdy;
  logic [DATA_WIDTH-1:0]       bus_rdata;

  modport master (
    input  req, req_mode, req_addr, req_wdata, bus_rdy, bus_rdata,
    output gnt, done, rdata, err, bus_start, bus_mode, bus_addr, bus_wdata
  );

  modport slave (
    output req, req_mode, req_addr, req_wdata, bus_rdy, bus_rdata,
    input  gnt, done, rdata, err, bus_start, bus_mode, bus_addr, bus_wdata
  );

endinterface

// File: rtl/simple_bus_arbiter.sv
// -----------------------------------------------------------------------------
// simple_bus_arbiter
//
// Round-robin arbiter and transaction sequencer sharing one simple_bus between
// N_REQ masters. In IDLE it picks the first requester at or after last+1
// (wrapping), grants it, latches its mode/address/write data, issues a
// one-cycle bus_start, waits for bus_rdy, then returns the read data with a
// one-cycle done pulse to the owner.
//
// Ports:
//   clk     - single clock, rising edge
//   reset   - synchronous, active-high
//   bus_if  - simple_bus_arbiter_if.master (request side + bus side)
//
// Parameters: N_REQ (2..8), ADDR_WIDTH, DATA_WIDTH, TIMEOUT.
//
// Optional feature, macro SIMPLE_BUS_ARB_TIMEOUT_EN:
//   defined   - a WAIT cycle counter aborts the transaction after TIMEOUT
//               WAIT cycles without bus_rdy, completing with err=1, rdata=0.
//               bus_rdy in the final counted cycle still completes normally.
//   undefined - WAIT lasts until bus_rdy; err is constant 0.
//
// Cycle timing, request first sampled at edge 0:
//   edge 0 IDLE->GRANT (gnt up), edge 1 GRANT->START (bus_* latched),
//   edge 2 START->WAIT (bus_start up for one cycle), edge 3+ WAIT samples
//   bus_rdy (done up), next edge DONE->IDLE (gnt and done down).
// -----------------------------------------------------------------------------
module simple_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  simple_bus_arbiter_if.master  bus_if
);

  localparam int IDX_W = $clog2(N_REQ);

  // Elaboration-time guard on the supported parameter range.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("simple_bus_arbiter: N_REQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        last_q;
  logic [IDX_W-1:0]        win_q;
  logic [N_REQ-1:0]        gnt_q;
  logic [N_REQ-1:0]        done_q;
  logic                    bus_start_q;
  logic [1:0]              bus_mode_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [DATA_WIDTH-1:0]   bus_wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]        wait_cnt_q;
  logic                    err_q;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: the first set req bit searching upward from last_q+1,
  // wrapping. The loop walks offsets from farthest to nearest so the nearest
  // set bit is the last one written and therefore wins.
  // ---------------------------------------------------------------------------
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (bus_if.req[(int'(last_q) + k) % N_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM. All outputs are registered here.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= IDX_W'(N_REQ - 1);  // requester 0 wins first after reset
      win_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      bus_start_q <= 1'b0;
      bus_mode_q  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; only their owning state raises them.
      bus_start_q <= 1'b0;
      done_q      <= '0;

      case (state_q)
        S_IDLE: begin
          if (arb_found) begin
            win_q          <= arb_idx;
            gnt_q          <= '0;
            gnt_q[arb_idx] <= 1'b1;
            state_q        <= S_GRANT;
          end
        end

        S_GRANT: begin
          bus_mode_q  <= bus_if.req_mode[2*win_q +: 2];
          bus_addr_q  <= bus_if.req_addr[win_q*ADDR_WIDTH +: ADDR_WIDTH];
          bus_wdata_q <= bus_if.req_wdata[win_q*DATA_WIDTH +: DATA_WIDTH];
          state_q     <= S_START;
        end

        // bus_rdy is deliberately not looked at here; the strobe issued on
        // this edge is visible during the first WAIT cycle.
        S_START: begin
          bus_start_q <= 1'b1;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
          wait_cnt_q  <= '0;
`endif
          state_q     <= S_WAIT;
        end

        S_WAIT: begin
          if (bus_if.bus_rdy) begin
            rdata_q <= bus_if.bus_rdata;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
          // The counter holds the number of WAIT cycles already elapsed, so
          // TIMEOUT-1 marks the final allowed cycle; rdy above takes priority.
          else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end

        S_DONE: begin
          last_q  <= win_q;
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_if.gnt       = gnt_q;
  assign bus_if.done      = done_q;
  assign bus_if.rdata     = rdata_q;
  assign bus_if.bus_start = bus_start_q;
  assign bus_if.bus_mode  = bus_mode_q;
  assign bus_if.bus_addr  = bus_addr_q;
  assign bus_if.bus_wdata = bus_wdata_q;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  assign bus_if.err       = err_q;
`else
  assign bus_if.err       = 1'b0;
`endif

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_simple_bus_arbiter
//
// Self-checking bench for simple_bus_arbiter. The reference model works at
// transaction level: it remembers the last served requester, picks the next
// winner from the round-robin rule, and derives the expected grant, bus
// fields, completion cycle, read data and error flag for each transaction.
// Directed cases cover the single request, simultaneous and alternating
// requesters, an owner dropping its request mid-transaction, reset during
// WAIT and (with SIMPLE_BUS_ARB_TIMEOUT_EN) the timeout boundary; a random
// phase then varies requests, payloads and bus latency every cycle.
// -----------------------------------------------------------------------------
module tb_simple_bus_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int TO  = 15;
  localparam int MW  = 2 * NR;
  localparam int AAW = AW * NR;
  localparam int ADW = DW * NR;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  simple_bus_arbiter_if #(.N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  simple_bus_arbiter #(
    .N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int last_m  = NR - 1;   // model: last served requester

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first set bit searching upward from last+1, wrapping.
  function automatic int pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic drive_rand();
    bus_if.req       = NR'($urandom);
    bus_if.req_mode  = MW'($urandom);
    bus_if.req_addr  = AAW'($urandom);
    bus_if.req_wdata = ADW'({$urandom, $urandom});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   64'(bus_if.gnt),       64'd0);
    check({tag, "_done"},  64'(bus_if.done),      64'd0);
    check({tag, "_start"}, 64'(bus_if.bus_start), 64'd0);
    check({tag, "_err"},   64'(bus_if.err),       64'd0);
    check({tag, "_mode"},  64'(bus_if.bus_mode),  64'd0);
    check({tag, "_addr"},  64'(bus_if.bus_addr),  64'd0);
    check({tag, "_wdata"}, 64'(bus_if.bus_wdata), 64'd0);
    check({tag, "_rdata"}, 64'(bus_if.rdata),     64'd0);
  endtask

  // One arbitration slot starting in IDLE. lat = WAIT cycles before bus_rdy
  // (0 = rdy in the first WAIT cycle). rd_val < 0 picks random read data.
  // rnd re-randomizes all request inputs every cycle; drop clears the
  // owner's req bit in the first WAIT cycle. won returns the winner or -1.
  task automatic run_txn(input int lat, input int rd_val, input bit rnd,
                         input bit drop, output int won);
    int                 w;
    int                 eff_lat;
    bit                 tmo;
    logic [1:0]         m;
    logic [AW-1:0]      a;
    logic [DW-1:0]      d;
    logic [DW-1:0]      rd;
    logic [63:0]        g;

    w   = pick(bus_if.req, last_m);
    won = w;
    if (w < 0) begin
      tick();
      check("idle_gnt",  64'(bus_if.gnt),  64'd0);
      check("idle_done", 64'(bus_if.done), 64'd0);
      return;
    end
    g = 64'(1) << w;

    tick();  // IDLE -> GRANT
    check("gnt_grant", 64'(bus_if.gnt),       g);
    check("start_e0",  64'(bus_if.bus_start), 64'd0);
    if (rnd) drive_rand();
    bus_if.bus_rdy = 1'($urandom);   // ignored outside WAIT
    m = bus_if.req_mode[2*w +: 2];
    a = bus_if.req_addr[w*AW +: AW];
    d = bus_if.req_wdata[w*DW +: DW];

    tick();  // GRANT -> START
    check("gnt_start", 64'(bus_if.gnt),       g);
    check("start_e1",  64'(bus_if.bus_start), 64'd0);
    if (rnd) drive_rand();
    bus_if.bus_rdy = 1'($urandom);

    tick();  // START -> WAIT
    check("start_pulse", 64'(bus_if.bus_start), 64'd1);
    check("bus_mode",    64'(bus_if.bus_mode),  64'(m));
    check("bus_addr",    64'(bus_if.bus_addr),  64'(a));
    check("bus_wdata",   64'(bus_if.bus_wdata), 64'(d));
    check("done_early",  64'(bus_if.done),      64'd0);

    eff_lat = lat;
    tmo     = 1'b0;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    if (lat >= TO) begin
      eff_lat = TO - 1;
      tmo     = 1'b1;
    end
`endif
    rd = '0;
    for (int i = 0; i <= eff_lat; i++) begin
      if (rnd) drive_rand();
      if (drop && i == 0) bus_if.req[w] = 1'b0;
      bus_if.bus_rdata = (rd_val >= 0) ? DW'(rd_val) : DW'($urandom);
      bus_if.bus_rdy   = (i == eff_lat) && !tmo;
      rd = bus_if.bus_rdata;
      tick();
      if (i < eff_lat) begin
        check("done_wait",  64'(bus_if.done),      64'd0);
        check("start_wait", 64'(bus_if.bus_start), 64'd0);
        check("gnt_wait",   64'(bus_if.gnt),       g);
        check("addr_hold",  64'(bus_if.bus_addr),  64'(a));
      end
    end
    bus_if.bus_rdy = 1'b0;
    check("done_pulse", 64'(bus_if.done),      g);
    check("gnt_done",   64'(bus_if.gnt),       g);
    check("rdata",      64'(bus_if.rdata),     tmo ? 64'd0 : 64'(rd));
    check("err",        64'(bus_if.err),       64'(tmo));
    check("start_done", 64'(bus_if.bus_start), 64'd0);
    last_m = w;
    if (rnd) drive_rand();

    tick();  // DONE -> IDLE
    check("gnt_clear",  64'(bus_if.gnt),   64'd0);
    check("done_clear", 64'(bus_if.done),  64'd0);
    check("rdata_hold", 64'(bus_if.rdata), tmo ? 64'd0 : 64'(rd));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    last_m = NR - 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int exp_order[5];

    bus_if.req       = '0;
    bus_if.req_mode  = '0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.bus_rdy   = 1'b0;
    bus_if.bus_rdata = '0;

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    reset  = 1'b0;
    last_m = NR - 1;

    // Single request from requester 1.
    bus_if.req              = 4'b0010;
    bus_if.req_addr[AW +: AW] = 8'h3C;
    bus_if.req_mode[2 +: 2]   = 2'b01;
    bus_if.req_wdata[DW +: DW] = 16'hBEEF;
    run_txn(0, 'h1234, 1'b0, 1'b0, w);
    check("single_winner", 64'(w), 64'd1);
    bus_if.req = '0;
    tick();
    check("single_no_regrant", 64'(bus_if.gnt), 64'd0);

    // All four requesting continuously after reset: 0,1,2,3,0.
    apply_reset();
    exp_order = '{0, 1, 2, 3, 0};
    bus_if.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      bus_if.req_addr  = AAW'($urandom);
      bus_if.req_wdata = ADW'({$urandom, $urandom});
      run_txn(0, -1, 1'b0, 1'b0, w);
      check("rr_order", 64'(w), 64'(exp_order[i]));
    end

    // Fairness between requesters 0 and 2 with two WAIT cycles.
    apply_reset();
    bus_if.req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      run_txn(2, -1, 1'b0, 1'b0, w);
      check("fair_order", 64'(w), (i % 2 == 0) ? 64'd0 : 64'd2);
    end

    // Requester 1 drops its request during WAIT.
    apply_reset();
    bus_if.req = 4'b0010;
    run_txn(1, -1, 1'b0, 1'b1, w);
    check("drop_winner", 64'(w), 64'd1);
    run_txn(0, -1, 1'b0, 1'b0, w);   // req now zero: must stay idle
    check("drop_no_grant", 64'(w + 1), 64'd0);

    // Reset asserted for one cycle in WAIT.
    bus_if.req = 4'b0100;
    tick();  // grant
    tick();  // latch
    tick();  // start
    tick();  // first WAIT cycle, no rdy
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_wait");
    reset          = 1'b0;
    last_m         = NR - 1;
    bus_if.req     = '0;
    bus_if.bus_rdy = 1'b1;
    tick();
    check("rst_wait_no_done", 64'(bus_if.done), 64'd0);
    check("rst_wait_no_gnt",  64'(bus_if.gnt),  64'd0);
    bus_if.bus_rdy = 1'b0;
    bus_if.req     = 4'b1111;
    run_txn(0, -1, 1'b0, 1'b0, w);
    check("rst_wait_first", 64'(w), 64'd0);

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    // Timeout with rdy never asserted, then the next requester is served;
    // rdy in the final counted WAIT cycle must complete without error.
    apply_reset();
    bus_if.req = 4'b0011;
    run_txn(100, -1, 1'b0, 1'b0, w);
    check("tmo_winner", 64'(w), 64'd0);
    run_txn(TO - 1, -1, 1'b0, 1'b0, w);
    check("tmo_next_winner", 64'(w), 64'd1);
`endif

    // Random phase.
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      drive_rand();
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
      run_txn(int'($urandom_range(0, 20)), -1, 1'b1, 1'b0, w);
`else
      run_txn(int'($urandom_range(0, 6)), -1, 1'b1, 1'b0, w);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
